iir_biquad_param: RTL and testbench

IIR_BIQUAD_PARAM -- requirements
Module: iir_biquad_param

---
 rtl/iir_biquad_param.sv | 110 +++++++++++
 tb/tb_iir_biquad_param.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/iir_biquad_param.sv
// Direct Form II biquad with a two-stage pipeline, shadowed coefficients, a delayed
// bypass path and optional saturation of the state and output with a sticky overflow flag.
module iir_bq_mulsh #(
  parameter int NB = 12
) (
  input  logic [NB-1:0] c,
  input  logic [NB-1:0] x,
  output logic [NB+1:0] q
);
  logic [2*NB-1:0] cx, xx, p;
  logic            unused_lsb;

  assign cx = {{NB{c[NB-1]}}, c};
  assign xx = {{NB{x[NB-1]}}, x};
  assign p  = cx * xx;
  // Q1.(NB-1) rescale: dropping the low NB-1 bits is an arithmetic shift with floor rounding.
  assign q  = {p[2*NB-1], p[2*NB-1:NB-1]};
  assign unused_lsb = ^p[NB-2:0];
endmodule

module iir_biquad_param #(
  parameter int NB     = 12,
  parameter bit SAT_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            vIn,
  input  logic [NB-1:0]   dIn,
  input  logic [3*NB-1:0] b,
  input  logic [2*NB-1:0] a,
  input  logic            cfg_ld,
  input  logic            bypass,
  input  logic            ovf_clr,
  output logic [NB-1:0]   dOut,
  output logic            vOut,
  output logic            ovf
);
  localparam int STAGES = 2;

  logic [STAGES:1]        vld_pipe;
  logic [NB-1:0]          s1_d;
  logic [2:0][NB-1:0]     b_sh;
  logic [1:0][NB-1:0]     a_sh;
  logic [NB-1:0]          w1, w2;
  logic [1:0][NB-1:0]     fb_x;
  logic [1:0][NB+1:0]     fb_q;
  logic [2:0][NB-1:0]     ff_x;
  logic [2:0][NB+1:0]     ff_q;
  logic [NB+1:0]          w_sum, y_sum;
  logic [NB-1:0]          w_n, y_n;
  logic                   ovf_set;

  // A NB+2 bit sum fits in NB bits only when its top three bits agree.
  function automatic logic out_rng(input logic [NB+1:0] s);
    return !((s[NB+1:NB-1] == 3'b000) || (s[NB+1:NB-1] == 3'b111));
  endfunction

  function automatic logic [NB-1:0] reduce(input logic [NB+1:0] s);
    if (SAT_EN && out_rng(s))
      return s[NB+1] ? {1'b1, {(NB-1){1'b0}}} : {1'b0, {(NB-1){1'b1}}};
    return s[NB-1:0];
  endfunction

  assign fb_x = {w2, w1};
  assign ff_x = {w2, w1, w_n};

  for (genvar i = 0; i < 2; i++) begin : g_fb
    iir_bq_mulsh #(.NB(NB)) u_mul (.c(a_sh[i]), .x(fb_x[i]), .q(fb_q[i]));
  end
  for (genvar i = 0; i < 3; i++) begin : g_ff
    iir_bq_mulsh #(.NB(NB)) u_mul (.c(b_sh[i]), .x(ff_x[i]), .q(ff_q[i]));
  end

  assign w_sum   = {{2{s1_d[NB-1]}}, s1_d} - fb_q[0] - fb_q[1];
  assign w_n     = reduce(w_sum);
  assign y_sum   = ff_q[0] + ff_q[1] + ff_q[2];
  assign y_n     = reduce(y_sum);
  assign ovf_set = vld_pipe[1] & ~bypass & (out_rng(w_sum) | out_rng(y_sum));
  assign vOut    = vld_pipe[STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_d     <= '0;
      b_sh     <= '0;
      a_sh     <= '0;
      w1       <= '0;
      w2       <= '0;
      dOut     <= '0;
      ovf      <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], vIn};
      s1_d     <= dIn;
      if (cfg_ld) begin
        b_sh <= b;
        a_sh <= a;
      end
      if (vld_pipe[1]) begin
        if (bypass) begin
          dOut <= s1_d;
        end else begin
          dOut <= y_n;
          w1   <= w_n;
          w2   <= w1;
        end
      end
      ovf <= ovf_set | (ovf & ~ovf_clr);
    end
  end
endmodule

// File: tb/tb_iir_biquad_param.sv
// Directed bench for iir_biquad_param (NB=12, SAT_EN=1) with a scoreboard fed by a
// fixed-point reference model at drive time and drained on every vOut pulse.
module tb_iir_biquad_param;
  localparam int     NB   = 12;
  localparam longint MAXV = 2047;
  localparam longint MINV = -2048;

  logic            clk = 1'b0, rst_n = 1'b1, vIn = 1'b0;
  logic            cfg_ld = 1'b0, bypass = 1'b0, ovf_clr = 1'b0;
  logic [NB-1:0]   dIn = '0;
  logic [3*NB-1:0] b = '0;
  logic [2*NB-1:0] a = '0;
  logic [NB-1:0]   dOut;
  logic            vOut, ovf;

  int              tests = 0, fails = 0;
  logic [NB-1:0]   exp_q[$];
  logic [NB-1:0]   mon_e;
  longint          mb[3], ma[2], mw1 = 0, mw2 = 0;
  logic [NB-1:0]   gx[3] = '{12'h200, 12'h000, 12'h000};
  logic [NB-1:0]   gy[3] = '{12'h100, 12'h080, 12'h040};

  iir_biquad_param #(.NB(NB), .SAT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .vIn(vIn), .dIn(dIn), .b(b), .a(a),
    .cfg_ld(cfg_ld), .bypass(bypass), .ovf_clr(ovf_clr),
    .dOut(dOut), .vOut(vOut), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic longint sx(input logic [NB-1:0] v);
    logic signed [NB-1:0] t;
    t = v;
    return longint'(t);
  endfunction

  function automatic longint mulsh(input longint c, input longint x);
    return (c * x) >>> (NB - 1);
  endfunction

  function automatic longint sat(input longint s);
    return (s > MAXV) ? MAXV : ((s < MINV) ? MINV : s);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    exp_q.delete();
    mw1 = 0;
    mw2 = 0;
    foreach (mb[i]) mb[i] = 0;
    foreach (ma[i]) ma[i] = 0;
  endtask

  task automatic do_reset();
    vIn = 1'b0;
    rst_n = 1'b0;
    model_clear();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic cfg(input logic [NB-1:0] b0, b1, b2, a1, a2);
    b = {b2, b1, b0};
    a = {a2, a1};
    cfg_ld = 1'b1;
    mb[0] = sx(b0); mb[1] = sx(b1); mb[2] = sx(b2);
    ma[0] = sx(a1); ma[1] = sx(a2);
    tick();
    cfg_ld = 1'b0;
  endtask

  // Presents one sample for the next edge and queues the model's answer for it.
  task automatic drive(input logic [NB-1:0] x);
    longint w, y;
    vIn = 1'b1;
    dIn = x;
    if (bypass) begin
      y = sx(x);
    end else begin
      w = sat(sx(x) - mulsh(ma[0], mw1) - mulsh(ma[1], mw2));
      y = sat(mulsh(mb[0], w) + mulsh(mb[1], mw1) + mulsh(mb[2], mw2));
      mw2 = mw1;
      mw1 = w;
    end
    exp_q.push_back(y[NB-1:0]);
  endtask

  always @(negedge clk) begin
    if (rst_n && vOut) begin
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL sb_unexpected got vOut=1 dOut=%0h expected no pulse", dOut);
      end
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        tests++;
        assert (dOut === mon_e) else begin
          fails++;
          $error("FAIL sb_dout got %0h expected %0h", dOut, mon_e);
        end
      end
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_dout", dOut, 0);
    chk("rst_vout", vOut, 0);
    chk("rst_ovf", ovf, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Coefficients are zero until the first load.
    drive(12'h200); tick(); vIn = 1'b0; tick();
    chk("uncfg_vout", vOut, 1);
    chk("uncfg_dout", dOut, 0);
    tick();

    // Pass-through gain and two-edge latency.
    cfg(12'h400, 12'h000, 12'h000, 12'h000, 12'h000);
    drive(12'h200); tick(); vIn = 1'b0;
    chk("lat_stage1", vOut, 0);
    tick();
    chk("pass_vout", vOut, 1);
    chk("pass_dout", dOut, 12'h100);
    tick();
    chk("pass_pulse", vOut, 0);

    // Feedback, back-to-back samples.
    do_reset();
    cfg(12'h400, 12'h000, 12'h000, 12'hC00, 12'h000);
    drive(12'h200); tick();
    drive(12'h000); tick();
    chk("fb_v0", vOut, 1); chk("fb_y0", dOut, 12'h100);
    drive(12'h000); tick();
    chk("fb_v1", vOut, 1); chk("fb_y1", dOut, 12'h080);
    vIn = 1'b0; tick();
    chk("fb_v2", vOut, 1); chk("fb_y2", dOut, 12'h040);
    tick();
    chk("fb_end_v", vOut, 0); chk("fb_end_hold", dOut, 12'h040);

    // Same feedback with three idle cycles between samples.
    do_reset();
    cfg(12'h400, 12'h000, 12'h000, 12'hC00, 12'h000);
    for (int i = 0; i < 3; i++) begin
      drive(gx[i]); tick(); vIn = 1'b0; tick();
      chk("gap_vout", vOut, 1);
      chk("gap_dout", dOut, gy[i]);
      repeat (2) begin
        tick();
        chk("gap_idle_v", vOut, 0);
        chk("gap_hold", dOut, gy[i]);
      end
    end

    // Saturation of w, sticky ovf, clear vs. simultaneous set.
    do_reset();
    cfg(12'h7FF, 12'h000, 12'h000, 12'hC00, 12'h000);
    drive(12'h7FF); tick();
    drive(12'h7FF); tick(); vIn = 1'b0;
    chk("sat_y0", dOut, 12'h7FE);
    chk("sat_ovf0", ovf, 0);
    tick();
    chk("sat_y1", dOut, 12'h7FE);
    chk("sat_w", dut.w1, 12'h7FF);
    chk("sat_ovf1", ovf, 1);
    drive(12'h7FF); tick(); vIn = 1'b0;
    ovf_clr = 1'b1; tick();
    chk("clr_set_wins", ovf, 1);
    tick();
    chk("clr_ovf", ovf, 0);
    ovf_clr = 1'b0;

    // Reset while two samples are in flight.
    drive(12'h7FF); tick();
    drive(12'h7FF); tick();
    chk("ms_pre_ovf", ovf, 1);
    drive(12'h7FF);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("ms_dout", dOut, 0);
    chk("ms_vout", vOut, 0);
    chk("ms_ovf", ovf, 0);
    model_clear();
    vIn = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      chk("ms_no_pulse", vOut, 0);
    end
    drive(12'h3FF); tick(); vIn = 1'b0; tick();
    chk("ms_coef0_v", vOut, 1);
    chk("ms_coef0_d", dOut, 0);

    // Bypass holds the state and leaves ovf alone.
    do_reset();
    cfg(12'h400, 12'h000, 12'h000, 12'hC00, 12'h000);
    drive(12'h200); tick(); vIn = 1'b0; tick();
    chk("byp_pre", dOut, 12'h100);
    bypass = 1'b1;
    drive(12'h123); tick(); vIn = 1'b0; tick();
    chk("byp_vout", vOut, 1);
    chk("byp_dout", dOut, 12'h123);
    bypass = 1'b0;
    drive(12'h000); tick(); vIn = 1'b0; tick();
    chk("byp_held", dOut, 12'h080);
    cfg(12'h7FF, 12'h000, 12'h000, 12'hC00, 12'h000);
    bypass = 1'b1;
    drive(12'h7FF); tick(); vIn = 1'b0; tick();
    chk("byp_big", dOut, 12'h7FF);
    chk("byp_ovf", ovf, 0);
    bypass = 1'b0;

    repeat (3) tick();
    chk("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
